vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 56, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 120, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 64, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 600, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 37, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 6, vertical sync width in lines.
REQ-008 SHALL have parameter V_BP, default 23, vertical back porch in lines.
REQ-009 SHALL have parameter HS_POL, default 0, asserted hs level (0 = active low).
REQ-010 SHALL have parameter VS_POL, default 0, asserted vs level (0 = active low).
REQ-011 SHALL have parameter COORD_W, default 11, coordinate width in bits.
REQ-012 SHALL have port Clk, input, 1, system clock.
REQ-013 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-014 SHALL have port pixel_ce, input, 1, pixel clock enable (used only when VGA_PIXEL_CE_EN is defined).
REQ-015 SHALL have port hs, output, 1, registered horizontal sync.
REQ-016 SHALL have port vs, output, 1, registered vertical sync.
REQ-017 SHALL have port blank, output, 1, high while in the active area, low otherwise.
REQ-018 SHALL have port sync, output, 1, composite sync, constant 0.
REQ-019 SHALL have port DrawX, output, COORD_W, horizontal count.
REQ-020 SHALL have port DrawY, output, COORD_W, vertical count.
REQ-021 SHALL have port line_start, output, 1, one-tick pulse at DrawX==0.
REQ-022 SHALL have port frame_start, output, 1, one-tick pulse at DrawX==0 and DrawY==0.
REQ-023 SHALL have port frame_cnt, output, 8, frame counter, wraps 255->0.

Function
REQ-024 "Tick" SHALL mean every Clk edge, or only Clk edges with pixel_ce=1 when VGA_PIXEL_CE_EN is defined; all state SHALL hold between ticks.
REQ-025 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL equal the sum of the V_* parameters.
REQ-026 DrawX SHALL count 0..H_TOTAL-1 and wrap to 0; it SHALL NOT reach H_TOTAL.
REQ-027 DrawY SHALL increment only on the tick where DrawX wraps, count 0..V_TOTAL-1, and wrap to 0.
REQ-028 hs SHALL equal HS_POL exactly when DrawX is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], and !HS_POL otherwise.
REQ-029 vs SHALL equal VS_POL exactly when DrawY is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], and !VS_POL otherwise.
REQ-030 hs, vs, line_start and frame_start SHALL be registered from next-count values, so they align with DrawX/DrawY in the same cycle (zero skew).
REQ-031 blank SHALL be combinational: 1 iff DrawX<H_ACTIVE and DrawY<V_ACTIVE.
REQ-032 frame_cnt SHALL increment on the same tick on which DrawX and DrawY both wrap to 0.
REQ-033 line_start and frame_start SHALL be high for exactly one Clk cycle per event, including when pixel_ce is held high continuously.
REQ-034 An elaboration-time check SHALL fail if any porch or sync parameter is 0, or if H_TOTAL or V_TOTAL exceeds 2**COORD_W.

Reset
REQ-035 Reset SHALL force DrawX=0, DrawY=0, frame_cnt=0, hs=!HS_POL, vs=!VS_POL, line_start=0, frame_start=0.
REQ-036 Reset asserted mid-line or mid-frame SHALL take effect immediately.
REQ-037 After release, the first tick SHALL give DrawX=1; no frame_start pulse SHALL occur until the first wrap.

Configuration
REQ-038 With VGA_PIXEL_CE_EN defined, counters and registered outputs SHALL advance only on ticks gated by pixel_ce (for example, 50 MHz Clk with pixel_ce every second cycle).
REQ-039 With VGA_PIXEL_CE_EN undefined, pixel_ce SHALL be ignored and the block SHALL advance on every Clk.

Structure
REQ-040 Package vga_pkg SHALL hold a vga_timing_t struct (all eight porch/sync/active fields plus polarities) and constants VGA_640X480_60 and VGA_800X600_72.
REQ-041 Sub-module vga_axis_counter (count, wrap, sync-window and pulse logic) SHALL be instantiated twice: horizontal, and vertical with the horizontal wrap as its enable.

Verification
REQ-042 With H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3, the bench SHALL check DrawX cycles 0..15, hs is low for DrawX 10..12, and blank is low for DrawX 8..15.
REQ-043 With V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (same H), the bench SHALL check DrawY increments after DrawX=15, vs is low for DrawY 5..6, and frame_start pulses every 128 cycles.
REQ-044 With HS_POL=1 and VS_POL=1, the bench SHALL check the sync windows are high and idle is low, including right after reset.
REQ-045 Asserting Reset at DrawX=5, DrawY=2 SHALL immediately zero the counters and frame_cnt; after release, the first frame_start SHALL come 128 cycles after the first tick.
REQ-046 With VGA_PIXEL_CE_EN defined and pixel_ce toggling 1,0,..., a full frame SHALL take 256 Clk cycles and each line_start SHALL be 1 Clk wide.
REQ-047 After 256 frames, frame_cnt SHALL wrap from 255 to 0 on the frame_start tick.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing types, standard mode constants and window helper.
package vga_pkg;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_active;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
        logic        hs_pol;
        logic        vs_pol;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480_60 = '{
        h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96,  h_bp: 16'd48,
        v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,   v_bp: 16'd33,
        hs_pol:   1'b0,    vs_pol: 1'b0
    };

    localparam vga_timing_t VGA_800X600_72 = '{
        h_active: 16'd800, h_fp: 16'd56, h_sync: 16'd120, h_bp: 16'd64,
        v_active: 16'd600, v_fp: 16'd37, v_sync: 16'd6,   v_bp: 16'd23,
        hs_pol:   1'b1,    vs_pol: 1'b1
    };

    // True when value lies in [lo, lo+len-1].
    function automatic logic in_window(input int unsigned value,
                                       input int unsigned lo,
                                       input int unsigned len);
        return (value >= lo) && (value < lo + len);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One display axis: position counter with wrap, registered sync window and
// registered start-of-axis pulse, all derived from the next count value.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int   ACTIVE = 8,
    parameter int   FP     = 2,
    parameter int   SYNC   = 3,
    parameter int   BP     = 3,
    parameter logic POL    = 1'b0,
    parameter int   W      = 11
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         tick,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         sync_out,
    output logic         start,
    output logic         active
);

    localparam int unsigned TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam int unsigned SYNC_START = ACTIVE + FP;

    logic         step;
    logic [W-1:0] count_next;

    assign step   = tick & en;
    assign wrap   = step && (count == W'(TOTAL - 1));
    assign active = (count < W'(ACTIVE));

    always_comb begin
        count_next = count;
        if (step) begin
            count_next = wrap ? '0 : count + 1'b1;
        end
    end

    // NOTE: start is cleared on every non-stepping Clk so it stays one Clk
    // wide even when the step enable is held for several cycles.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count    <= '0;
            sync_out <= ~POL;
            start    <= 1'b0;
        end else begin
            count <= count_next;
            start <= step && (count_next == '0);
            if (step) begin
                sync_out <= in_window(32'(count_next), SYNC_START, SYNC) ? POL : ~POL;
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal and vertical axis counters plus frame count.
// Define VGA_PIXEL_CE_EN to advance only on Clk edges qualified by pixel_ce.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 56,
    parameter int   H_SYNC   = 120,
    parameter int   H_BP     = 64,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 37,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 23,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   COORD_W  = 11
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               pixel_ce,
    output logic               hs,
    output logic               vs,
    output logic               blank,
    output logic               sync,
    output logic [COORD_W-1:0] DrawX,
    output logic [COORD_W-1:0] DrawY,
    output logic               line_start,
    output logic               frame_start,
    output logic [7:0]         frame_cnt
);

    localparam longint H_TOTAL = longint'(H_ACTIVE) + H_FP + H_SYNC + H_BP;
    localparam longint V_TOTAL = longint'(V_ACTIVE) + V_FP + V_SYNC + V_BP;
    localparam longint COORD_SPAN = longint'(1) << COORD_W;

    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        H_TOTAL > COORD_SPAN || V_TOTAL > COORD_SPAN) begin : g_param_check
        $error("vga_timing_gen: zero porch/sync width or total exceeds coordinate range");
    end

    logic tick;
`ifdef VGA_PIXEL_CE_EN
    assign tick = pixel_ce;
`else
    logic pixel_ce_unused;
    assign pixel_ce_unused = pixel_ce;
    assign tick = 1'b1;
`endif

    logic h_wrap;
    logic h_active;
    logic v_wrap;
    logic v_active;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL),
        .W      (COORD_W)
    ) u_h_axis (
        .Clk      (Clk),
        .Reset    (Reset),
        .tick     (tick),
        .en       (1'b1),
        .count    (DrawX),
        .wrap     (h_wrap),
        .sync_out (hs),
        .start    (line_start),
        .active   (h_active)
    );

    // The vertical axis steps only on the tick where the line wraps, so its
    // start pulse is exactly the frame boundary.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL),
        .W      (COORD_W)
    ) u_v_axis (
        .Clk      (Clk),
        .Reset    (Reset),
        .tick     (tick),
        .en       (h_wrap),
        .count    (DrawY),
        .wrap     (v_wrap),
        .sync_out (vs),
        .start    (frame_start),
        .active   (v_active)
    );

    assign blank = h_active & v_active;
    assign sync  = 1'b0;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_cnt <= '0;
        end else if (v_wrap) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen against a tick-count arithmetic model.
// Honours VGA_PIXEL_CE_EN when the bench is built with it defined.
module tb_vga_timing_gen;

    localparam int H_A = 8, H_F = 2, H_S = 3, H_B = 3;
    localparam int V_A = 4, V_F = 1, V_S = 2, V_B = 1;
    localparam int H_T = H_A + H_F + H_S + H_B;   // 16
    localparam int V_T = V_A + V_F + V_S + V_B;   // 8
    localparam int FRAME = H_T * V_T;             // 128
    localparam int CW = 11;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          pixel_ce = 1'b0;

    logic          hs, vs, blank, sync, line_start, frame_start;
    logic [CW-1:0] DrawX, DrawY;
    logic [7:0]    frame_cnt;

    logic          hs_p, vs_p, blank_p, sync_p, line_start_p, frame_start_p;
    logic [CW-1:0] DrawX_p, DrawY_p;
    logic [7:0]    frame_cnt_p;

    int unsigned   n_checks = 0;
    int unsigned   n_fail = 0;

    // Model: ticks since reset release plus the pulses expected this cycle.
    int unsigned   n_ticks = 0;
    bit            ls_exp = 1'b0;
    bit            fs_exp = 1'b0;

    always #5 Clk = ~Clk;

    vga_timing_gen #(
        .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
        .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B),
        .HS_POL(1'b0), .VS_POL(1'b0), .COORD_W(CW)
    ) u_dut (
        .Clk(Clk), .Reset(Reset), .pixel_ce(pixel_ce),
        .hs(hs), .vs(vs), .blank(blank), .sync(sync),
        .DrawX(DrawX), .DrawY(DrawY),
        .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    vga_timing_gen #(
        .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
        .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B),
        .HS_POL(1'b1), .VS_POL(1'b1), .COORD_W(CW)
    ) u_dut_pol (
        .Clk(Clk), .Reset(Reset), .pixel_ce(pixel_ce),
        .hs(hs_p), .vs(vs_p), .blank(blank_p), .sync(sync_p),
        .DrawX(DrawX_p), .DrawY(DrawY_p),
        .line_start(line_start_p), .frame_start(frame_start_p), .frame_cnt(frame_cnt_p)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_tick();
`ifdef VGA_PIXEL_CE_EN
        return pixel_ce;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_update();
        if (Reset) begin
            n_ticks = 0;
            ls_exp  = 1'b0;
            fs_exp  = 1'b0;
        end else if (model_tick()) begin
            n_ticks++;
            ls_exp = (n_ticks % H_T) == 0;
            fs_exp = (n_ticks % FRAME) == 0;
        end else begin
            ls_exp = 1'b0;
            fs_exp = 1'b0;
        end
    endtask

    task automatic compare_all();
        int unsigned x, y, fc;
        bit in_hs, in_vs, act;
        x  = n_ticks % H_T;
        y  = (n_ticks / H_T) % V_T;
        fc = (n_ticks / FRAME) % 256;
        in_hs = (x >= H_A + H_F) && (x <= H_A + H_F + H_S - 1);
        in_vs = (y >= V_A + V_F) && (y <= V_A + V_F + V_S - 1);
        act   = (x < H_A) && (y < V_A);
        check("drawx", 32'(DrawX), x);
        check("drawy", 32'(DrawY), y);
        check("hs", 32'(hs), 32'(!in_hs));
        check("vs", 32'(vs), 32'(!in_vs));
        check("blank", 32'(blank), 32'(act));
        check("sync", 32'(sync), 0);
        check("line_start", 32'(line_start), 32'(ls_exp));
        check("frame_start", 32'(frame_start), 32'(fs_exp));
        check("frame_cnt", 32'(frame_cnt), fc);
        check("pol_drawx", 32'(DrawX_p), x);
        check("pol_drawy", 32'(DrawY_p), y);
        check("pol_hs", 32'(hs_p), 32'(in_hs));
        check("pol_vs", 32'(vs_p), 32'(in_vs));
        check("pol_blank", 32'(blank_p), 32'(act));
    endtask

    task automatic step_cycle(input bit rst, input bit ce);
        @(negedge Clk);
        Reset    = rst;
        pixel_ce = ce;
        #1;
        if (rst) begin
            check("rst_now_drawx", 32'(DrawX), 0);
            check("rst_now_drawy", 32'(DrawY), 0);
            check("rst_now_fcnt", 32'(frame_cnt), 0);
            check("rst_now_hs", 32'(hs), 1);
            check("rst_now_pol_hs", 32'(hs_p), 0);
            check("rst_now_pol_vs", 32'(vs_p), 0);
        end
        @(posedge Clk);
        model_update();
        #1;
        compare_all();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned cnt;
        int unsigned wraps;
        logic [7:0]  prev_fc;

        // Reset state, including idle levels of both polarities.
        repeat (3) step_cycle(1'b1, 1'b0);

        // Run to DrawX=5, DrawY=2, then reset mid-frame.
        for (int i = 0; i < 2 * H_T + 5; i++) step_cycle(1'b0, 1'b1);
        check("pre_rst_drawx", 32'(DrawX), 5);
        check("pre_rst_drawy", 32'(DrawY), 2);
        step_cycle(1'b1, 1'b1);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            step_cycle(1'b0, 1'b1);
            cnt++;
            if (i == 0) check("first_tick_drawx", 32'(DrawX), 1);
            if (frame_start) break;
        end
        check("first_fs_ticks", cnt, FRAME);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            step_cycle(1'b0, 1'b1);
            cnt++;
            if (frame_start) break;
        end
        check("fs_period", cnt, FRAME);

        // Random pixel_ce and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step_cycle($urandom_range(0, 499) == 0, 1'($urandom_range(0, 1)));
        end

        // 256 frames with pixel_ce held high: frame_cnt must wrap to 0.
        step_cycle(1'b1, 1'b1);
        wraps   = 0;
        prev_fc = frame_cnt;
        for (int i = 0; i < 256 * FRAME + 4; i++) begin
            step_cycle(1'b0, 1'b1);
            if (frame_start && prev_fc == 8'd255) begin
                wraps++;
                check("fcnt_wrap", 32'(frame_cnt), 0);
            end
            prev_fc = frame_cnt;
        end
        check("fcnt_wrap_count", wraps, 1);

`ifdef VGA_PIXEL_CE_EN
        // pixel_ce toggling 1,0: two Clk per pixel, pulses still one Clk.
        begin
            int unsigned ls_run, ls_max;
            step_cycle(1'b1, 1'b0);
            cnt = 0;
            ls_run = 0;
            ls_max = 0;
            for (int i = 0; i < 2000; i++) begin
                step_cycle(1'b0, (i % 2) == 0);
                cnt++;
                ls_run = line_start ? ls_run + 1 : 0;
                if (ls_run > ls_max) ls_max = ls_run;
                if (frame_start) break;
            end
            check("ce_first_frame_clks", cnt, 2 * FRAME - 1);
            cnt = 0;
            for (int i = 0; i < 2000; i++) begin
                step_cycle(1'b0, (i % 2) == 1);
                cnt++;
                ls_run = line_start ? ls_run + 1 : 0;
                if (ls_run > ls_max) ls_max = ls_run;
                if (frame_start) break;
            end
            check("ce_frame_clks", cnt, 2 * FRAME);
            check("ce_line_start_width", ls_max, 1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
